// File: rtl/irq_sequencer_if.sv
// Pipeline-side bundle for the interrupt sequencer: ID-stage status in, PCSrc/flush/EPC controls out.
// The pipeline (or bench) uses master; the sequencer uses slave.
interface irq_sequencer_if #(
    parameter int LAT_W = 8
);
    logic             irq_in;
    logic             id_valid;
    logic [31:0]      id_pc;
    logic             id_branch;
    logic             id_jump;
    logic             id_eret;
    logic             load_stall;
    logic             take;
    logic             flush_ifid;
    logic             flush_idex;
    logic [31:0]      pc_vector;
    logic             epc_we;
    logic [4:0]       epc_rd;
    logic [31:0]      epc;
    logic             in_isr;
    logic             pending;
    logic [LAT_W-1:0] irq_lat;

    modport master (
        output irq_in, id_valid, id_pc, id_branch, id_jump, id_eret, load_stall,
        input  take, flush_ifid, flush_idex, pc_vector, epc_we, epc_rd, epc,
        input  in_isr, pending, irq_lat
    );

    modport slave (
        input  irq_in, id_valid, id_pc, id_branch, id_jump, id_eret, load_stall,
        output take, flush_ifid, flush_idex, pc_vector, epc_we, epc_rd, epc,
        output in_isr, pending, irq_lat
    );
endinterface

// File: rtl/irq_sequencer.sv
// Interrupt entry/exit sequencer: picks a safe ID instruction to break on, flushes, captures EPC, tracks ISR until ERET.
// Latency: irq_in to take >= 2 cycles (4 with IRQ_SYNC_EN); ARM holds off while ID is a bubble, stalled, or in a branch/delay-slot pair.
// Optional: define IRQ_SYNC_EN to pass irq_in through a 2-flop synchronizer.
module irq_sequencer #(
    parameter logic [31:0] VECTOR  = 32'h8000_0004,
    parameter logic [4:0]  EPC_REG = 5'd26,
    parameter int          LAT_W   = 8
) (
    input  logic           clk,
    input  logic           reset,
    irq_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ARM, TAKE, ISR, RET} state_t;

    localparam logic [LAT_W-1:0] CNT_ONE = {{(LAT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             pend_q, pend_d;
    logic             isr_q, isr_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [31:0]      epc_q, epc_d;
    logic             prev_br_q;
    logic             irq_s;
    logic             safe;
    logic             eret_ok;
    logic             take_c;

`ifdef IRQ_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= 2'b00;
        else        sync_q <= {sync_q[0], bus.irq_in};
    end

    assign irq_s = sync_q[1];
`else
    assign irq_s = bus.irq_in;
`endif

    // A branch/jump seen last cycle means ID now holds its delay slot, which must not be split off.
    assign safe    = bus.id_valid && !bus.load_stall && !bus.id_branch && !bus.id_jump && !prev_br_q;
    assign eret_ok = bus.id_eret && bus.id_valid && !bus.load_stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            pend_q    <= 1'b0;
            isr_q     <= 1'b0;
            cnt_q     <= '0;
            lat_q     <= '0;
            epc_q     <= 32'h0;
            prev_br_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            isr_q     <= isr_d;
            cnt_q     <= cnt_d;
            lat_q     <= lat_d;
            epc_q     <= epc_d;
            prev_br_q <= bus.id_valid && (bus.id_branch || bus.id_jump);
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        isr_d   = isr_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        epc_d   = epc_q;
        take_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (irq_s) begin
                    pend_d = 1'b1;
                    if (!isr_q) begin
                        state_d = ARM;
                        cnt_d   = '0;
                    end
                end
            end
            ARM: begin
                if (cnt_q != '1) cnt_d = cnt_q + CNT_ONE;
                if (safe) state_d = TAKE;
            end
            TAKE: begin
                take_c  = 1'b1;
                epc_d   = bus.id_pc;
                lat_d   = cnt_q;
                pend_d  = 1'b0;
                isr_d   = 1'b1;
                state_d = ISR;
            end
            ISR: begin
                if (irq_s)   pend_d  = 1'b1;
                if (eret_ok) state_d = RET;
            end
            RET: begin
                isr_d = 1'b0;
                // A request that lands during the return cycle still counts.
                if (pend_q || irq_s) begin
                    pend_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ARM;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.take       = take_c;
    assign bus.flush_ifid = take_c;
    assign bus.flush_idex = take_c;
    assign bus.epc_we     = take_c;
    assign bus.epc_rd     = EPC_REG;
    assign bus.pc_vector  = VECTOR;
    // EPC and latency are shown live during TAKE so the WB write carries the current ID PC.
    assign bus.epc        = take_c ? bus.id_pc : epc_q;
    assign bus.irq_lat    = take_c ? cnt_q : lat_q;
    assign bus.pending    = pend_q && !take_c;
    assign bus.in_isr     = isr_q;
endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench for irq_sequencer: reset, minimum latency, delay-slot and load-stall holdoff, nested request, reset during TAKE.
module tb_irq_sequencer;
`ifdef IRQ_SYNC_EN
    localparam int LAT_MIN = 4;
`else
    localparam int LAT_MIN = 2;
`endif
    localparam int ARM_DLY = LAT_MIN - 1;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    irq_sequencer_if #(.LAT_W(8)) bus ();

    irq_sequencer #(
        .VECTOR (32'h8000_0004),
        .EPC_REG(5'd26),
        .LAT_W  (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic br,
                          input logic jp, input logic er, input logic st);
        bus.id_valid   = v;
        bus.id_pc      = pc;
        bus.id_branch  = br;
        bus.id_jump    = jp;
        bus.id_eret    = er;
        bus.load_stall = st;
    endtask

    // Called just after a posedge while in ISR; leaves the sequencer in IDLE.
    task automatic do_eret(input string tag);
        set_id(1'b1, 32'h0000_0200, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 32'h0000_0204, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        smp();
        check(tag, 32'(bus.in_isr), 32'd0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        logic found;

        reset      = 1'b0;
        bus.irq_in = 1'b0;
        set_id(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        smp();
        check("rst_take",    32'(bus.take),     32'd0);
        check("rst_in_isr",  32'(bus.in_isr),   32'd0);
        check("rst_epc",     bus.epc,           32'h0);
        check("rst_vector",  bus.pc_vector,     32'h8000_0004);
        check("rst_pending", 32'(bus.pending),  32'd0);
        check("rst_lat",     32'(bus.irq_lat),  32'd0);
        check("rst_epc_we",  32'(bus.epc_we),   32'd0);
        tick();

        // Minimum latency with a steady, hazard-free ID stream.
        set_id(1'b1, 32'h0000_0040, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.irq_in = 1'b1;
        n = 0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            smp();
            if (bus.take) begin
                found = 1'b1;
                break;
            end
            tick();
            bus.irq_in = 1'b0;
            n++;
        end
        check("t1_take_seen", 32'(found), 32'd1);
        check("t1_latency",   32'(n),     32'(LAT_MIN));
        check("t1_epc",       bus.epc,    32'h0000_0040);
        check("t1_epc_we",    32'(bus.epc_we),     32'd1);
        check("t1_flush_ifid",32'(bus.flush_ifid), 32'd1);
        check("t1_flush_idex",32'(bus.flush_idex), 32'd1);
        check("t1_epc_rd",    32'(bus.epc_rd),     32'd26);
        check("t1_lat",       32'(bus.irq_lat),    32'd1);
        check("t1_pending",   32'(bus.pending),    32'd0);
        tick();
        set_id(1'b1, 32'h0000_0044, 1'b0, 1'b0, 1'b0, 1'b0);
        smp();
        check("t1_in_isr",    32'(bus.in_isr),  32'd1);
        check("t1_take_once", 32'(bus.take),    32'd0);
        check("t1_epc_held",  bus.epc,          32'h0000_0040);
        tick();
        do_eret("t1_eret_exit");

        // Branch at 0x44 with delay slot 0x48: first legal break is 0x4C.
        set_id(1'b1, 32'h0000_0040, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.irq_in = 1'b1;
        repeat (ARM_DLY) tick();
        set_id(1'b1, 32'h0000_0044, 1'b1, 1'b0, 1'b0, 1'b0);
        smp();
        check("t2_pending",    32'(bus.pending), 32'd1);
        check("t2_no_take_br", 32'(bus.take),    32'd0);
        tick();
        bus.irq_in = 1'b0;
        set_id(1'b1, 32'h0000_0048, 1'b0, 1'b0, 1'b0, 1'b0);
        smp();
        check("t2_no_take_slot", 32'(bus.take), 32'd0);
        tick();
        set_id(1'b1, 32'h0000_004C, 1'b0, 1'b0, 1'b0, 1'b0);
        smp();
        check("t2_no_take_arm", 32'(bus.take), 32'd0);
        tick();
        smp();
        check("t2_take", 32'(bus.take),    32'd1);
        check("t2_epc",  bus.epc,          32'h0000_004C);
        check("t2_lat",  32'(bus.irq_lat), 32'd3);
        tick();
        do_eret("t2_eret_exit");

        // Load-use stall for 4 ARM cycles.
        set_id(1'b1, 32'h0000_0050, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.irq_in = 1'b1;
        repeat (ARM_DLY) tick();
        bus.irq_in = 1'b0;
        bus.load_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            smp();
            check("t3_no_take_stall", 32'(bus.take), 32'd0);
            tick();
        end
        bus.load_stall = 1'b0;
        smp();
        check("t3_no_take_release", 32'(bus.take), 32'd0);
        tick();
        smp();
        check("t3_take", 32'(bus.take),    32'd1);
        check("t3_epc",  bus.epc,          32'h0000_0050);
        check("t3_lat",  32'(bus.irq_lat), 32'd5);
        tick();

        // Request inside the ISR is held, serviced after ERET via ARM.
        bus.irq_in = 1'b1;
        tick();
        bus.irq_in = 1'b0;
        repeat (3) tick();
        smp();
        check("t4_pending_isr", 32'(bus.pending), 32'd1);
        check("t4_in_isr",      32'(bus.in_isr),  32'd1);
        check("t4_masked",      32'(bus.take),    32'd0);
        set_id(1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 32'h0000_0104, 1'b0, 1'b0, 1'b0, 1'b0);
        smp();
        check("t4_ret_in_isr",  32'(bus.in_isr),  32'd1);
        check("t4_ret_pending", 32'(bus.pending), 32'd1);
        tick();
        smp();
        check("t4_arm_in_isr", 32'(bus.in_isr), 32'd0);
        check("t4_arm_take",   32'(bus.take),   32'd0);
        tick();
        smp();
        check("t4_take2",         32'(bus.take),    32'd1);
        check("t4_epc2",          bus.epc,          32'h0000_0104);
        check("t4_lat2",          32'(bus.irq_lat), 32'd1);
        check("t4_pending_clear", 32'(bus.pending), 32'd0);
        tick();
        smp();
        check("t4_isr_again", 32'(bus.in_isr),  32'd1);
        check("t4_no_pend",   32'(bus.pending), 32'd0);
        tick();
        do_eret("t4_eret_exit");

        // Asynchronous reset in the middle of a TAKE cycle.
        set_id(1'b1, 32'h0000_0060, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.irq_in = 1'b1;
        tick();
        bus.irq_in = 1'b0;
        repeat (LAT_MIN - 1) tick();
        smp();
        check("t5_take_before_rst", 32'(bus.take), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("t5_rst_take",    32'(bus.take),       32'd0);
        check("t5_rst_epc_we",  32'(bus.epc_we),     32'd0);
        check("t5_rst_flush",   32'(bus.flush_ifid), 32'd0);
        check("t5_rst_in_isr",  32'(bus.in_isr),     32'd0);
        check("t5_rst_epc",     bus.epc,             32'h0);
        check("t5_rst_lat",     32'(bus.irq_lat),    32'd0);
        check("t5_rst_pending", 32'(bus.pending),    32'd0);
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            smp();
            check("t5_post_epc_we", 32'(bus.epc_we), 32'd0);
            check("t5_post_in_isr", 32'(bus.in_isr), 32'd0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
